// File: rtl/mem_bus.sv
// mem_bus: CPU-side memory bus controller.
//
// Decodes each CPU access to one of three targets:
//   - FFFF:                   interrupt-enable register (reads return {3'b111, ie})
//   - HRAM_BASE..FFFE:        internal HRAM (127 x 8, not reset)
//   - anything else:          forwarded to the external system bus
// With MEM_BUS_DMA_EN defined, FF46 is the OAM DMA register. A write to it
// starts a DMA_LEN-byte copy from {src_hi, idx} on the external bus into OAM.
// While the engine is busy, the CPU only reaches HRAM, FF46 and FFFF. Other
// reads return FF and other writes are dropped. Without the macro, FF46 is an
// ordinary external address and the OAM/DMA outputs are tied to 0.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   cpu_rd_en/cpu_wr_en        CPU strobes (write wins if both are high)
//   cpu_addr, cpu_wdata        CPU address / write data
//   cpu_rdata                  combinational read data (FF when no read)
//   ext_rd_en/ext_wr_en        external bus strobes
//   ext_addr, ext_wdata        external bus address / write data
//   ext_rdata                  external read data (same cycle)
//   oam_we/oam_addr/oam_wdata  OAM write port driven by the DMA engine
//   dma_active                 high from the START cycle through the last transfer
//   ie                         interrupt-enable bits
//
// Handshake: there is no back-pressure. A strobe is an access in that cycle.
// Reads complete combinationally. Writes commit at the next rising clk edge.
module mem_bus #(
    parameter logic [15:0] HRAM_BASE = 16'hFF80,
    parameter int          DMA_LEN   = 160
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cpu_rd_en,
    input  logic        cpu_wr_en,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        ext_rd_en,
    output logic        ext_wr_en,
    output logic [15:0] ext_addr,
    output logic [7:0]  ext_wdata,
    input  logic [7:0]  ext_rdata,
    output logic        oam_we,
    output logic [7:0]  oam_addr,
    output logic [7:0]  oam_wdata,
    output logic        dma_active,
    output logic [4:0]  ie
);

    localparam int HRAM_DEPTH = 32'hFFFF - int'(HRAM_BASE);
    localparam int HRAM_AW    = $clog2(HRAM_DEPTH);

    // A simultaneous read and write is treated as a write only.
    logic wr_act;
    logic rd_act;
    assign wr_act = cpu_wr_en;
    assign rd_act = cpu_rd_en && !cpu_wr_en;

    logic is_ie;
    logic is_hram;
    logic is_dma_reg;
    logic is_internal;
    assign is_ie       = (cpu_addr == 16'hFFFF);
    assign is_hram     = (cpu_addr >= HRAM_BASE) && (cpu_addr != 16'hFFFF);
    assign is_internal = is_ie || is_hram || is_dma_reg;

    // DMA engine view shared by the decode/mux logic below.
    logic        dma_busy;
    logic        dma_xfer;
    logic [15:0] dma_ext_addr;
    logic [7:0]  dma_reg_val;

    // ------------------------------------------------------------------
    // HRAM: combinational read, write on the clock edge, no reset.
    // ------------------------------------------------------------------
    logic [7:0]         hram_q [HRAM_DEPTH];
    logic [HRAM_AW-1:0] hram_idx;
    logic               hram_we;
    assign hram_idx = HRAM_AW'(cpu_addr - HRAM_BASE);
    assign hram_we  = wr_act && is_hram;

    always_ff @(posedge clk) begin
        if (hram_we) begin
            hram_q[hram_idx] <= cpu_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Interrupt-enable register
    // ------------------------------------------------------------------
    logic [4:0] ie_q;
    logic [4:0] ie_d;
    always_comb begin
        ie_d = ie_q;
        if (wr_act && is_ie) begin
            ie_d = cpu_wdata[4:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ie_q <= 5'd0;
        end else begin
            ie_q <= ie_d;
        end
    end
    assign ie = ie_q;

`ifdef MEM_BUS_DMA_EN
    // ------------------------------------------------------------------
    // OAM DMA engine
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_XFER  = 2'd2
    } dma_state_e;

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    dma_state_e state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] dma_reg_q, dma_reg_d;
    logic [7:0] src_hi;
    logic       dma_wr;

    assign is_dma_reg = (cpu_addr == 16'hFF46);
    assign dma_wr     = wr_act && is_dma_reg;

    // E0..FF sources fold onto C0..DF (WRAM echo).
    assign src_hi = (dma_reg_q >= 8'hE0) ? (dma_reg_q & 8'hDF) : dma_reg_q;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        dma_reg_d = dma_reg_q;
        if (dma_wr) begin
            dma_reg_d = cpu_wdata;
        end
        case (state_q)
            ST_IDLE: begin
                if (dma_wr) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                idx_d   = 8'd0;
                state_d = dma_wr ? ST_START : ST_XFER;
            end
            ST_XFER: begin
                // A rewrite of FF46 lets this cycle's byte complete, then
                // restarts from START with the new source.
                if (dma_wr) begin
                    state_d = ST_START;
                    idx_d   = 8'd0;
                end else if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                end else begin
                    idx_d = idx_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= 8'd0;
            dma_reg_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            dma_reg_q <= dma_reg_d;
        end
    end

    assign dma_busy     = (state_q != ST_IDLE);
    assign dma_xfer     = (state_q == ST_XFER);
    assign dma_ext_addr = {src_hi, idx_q};
    assign dma_reg_val  = dma_reg_q;

    assign dma_active = dma_busy;
    assign oam_we     = dma_xfer;
    assign oam_addr   = dma_xfer ? idx_q : 8'd0;
    assign oam_wdata  = dma_xfer ? ext_rdata : 8'd0;
`else
    // Without the engine, DMA_LEN has no effect. It is only touched here.
    logic [7:0] unused_len;
    assign unused_len = 8'(DMA_LEN);

    assign is_dma_reg   = 1'b0;
    assign dma_busy     = 1'b0;
    assign dma_xfer     = 1'b0;
    assign dma_ext_addr = 16'd0;
    assign dma_reg_val  = 8'h00;

    assign dma_active = 1'b0;
    assign oam_we     = 1'b0;
    assign oam_addr   = 8'd0;
    assign oam_wdata  = 8'd0;
`endif

    // ------------------------------------------------------------------
    // CPU read data
    // ------------------------------------------------------------------
    always_comb begin
        cpu_rdata = 8'hFF;
        if (rd_act) begin
            if (is_ie) begin
                cpu_rdata = {3'b111, ie_q};
            end else if (is_hram) begin
                cpu_rdata = hram_q[hram_idx];
            end else if (is_dma_reg) begin
                cpu_rdata = dma_reg_val;
            end else if (!dma_busy) begin
                cpu_rdata = ext_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // External bus: the DMA transfer owns it. Otherwise it carries forwarded
    // CPU accesses only. The CPU is locked out for the whole DMA,
    // including START.
    // ------------------------------------------------------------------
    logic fwd;
    assign fwd = (rd_act || wr_act) && !is_internal && !dma_busy;

    always_comb begin
        ext_rd_en = 1'b0;
        ext_wr_en = 1'b0;
        ext_addr  = 16'd0;
        ext_wdata = 8'd0;
        if (dma_xfer) begin
            ext_rd_en = 1'b1;
            ext_addr  = dma_ext_addr;
        end else if (fwd) begin
            ext_rd_en = rd_act;
            ext_wr_en = wr_act;
            ext_addr  = cpu_addr;
            ext_wdata = wr_act ? cpu_wdata : 8'd0;
        end
    end

endmodule

// File: tb/tb_mem_bus.sv
// tb_mem_bus: self-checking bench for mem_bus.
// Table-driven decode vectors, randomized accesses against a reference model,
// and hand-written DMA sequences. The DMA sequences are compiled only when
// MEM_BUS_DMA_EN is defined.
module tb_mem_bus;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_rd_en = 1'b0;
    logic        cpu_wr_en = 1'b0;
    logic [15:0] cpu_addr = 16'd0;
    logic [7:0]  cpu_wdata = 8'd0;
    logic [7:0]  cpu_rdata;
    logic        ext_rd_en;
    logic        ext_wr_en;
    logic [15:0] ext_addr;
    logic [7:0]  ext_wdata;
    logic [7:0]  ext_rdata;
    logic        oam_we;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        dma_active;
    logic [4:0]  ie;

    int errors = 0;
    int checks = 0;

    mem_bus dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_rd_en  (cpu_rd_en),
        .cpu_wr_en  (cpu_wr_en),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .ext_rd_en  (ext_rd_en),
        .ext_wr_en  (ext_wr_en),
        .ext_addr   (ext_addr),
        .ext_wdata  (ext_wdata),
        .ext_rdata  (ext_rdata),
        .oam_we     (oam_we),
        .oam_addr   (oam_addr),
        .oam_wdata  (oam_wdata),
        .dma_active (dma_active),
        .ie         (ie)
    );

    // ---------------- clock / external memory / OAM capture ----------------
    always #5 clk = ~clk;

    // External memory: every location reads as its low address byte ^ 5A.
    assign ext_rdata = ext_addr[7:0] ^ 8'h5A;

    logic [7:0] oam_mem [0:255];
    always @(posedge clk) begin
        if (oam_we) oam_mem[oam_addr] <= oam_wdata;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d);
        cpu_rd_en = rd;
        cpu_wr_en = wr;
        cpu_addr  = a;
        cpu_wdata = d;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- decode vector table ----------------
    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
        logic        exp_xrd;
        logic        exp_xwr;
        logic [15:0] exp_xaddr;
        logic [7:0]  exp_xwdata;
        logic [4:0]  exp_ie;
    } vec_t;

    function automatic vec_t mk(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d,
                                input logic [7:0] er, input logic xr, input logic xw,
                                input logic [15:0] xa, input logic [7:0] xd, input logic [4:0] e_ie);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = a; v.wdata = d;
        v.exp_rdata = er; v.exp_xrd = xr; v.exp_xwr = xw;
        v.exp_xaddr = xa; v.exp_xwdata = xd; v.exp_ie = e_ie;
        return v;
    endfunction

    vec_t vecs[$];

    // ---------------- reference model state ----------------
    logic [7:0] hram_m [0:126];
    logic [4:0] ie_m;
    logic [7:0] dma_reg_m;

`ifdef MEM_BUS_DMA_EN
    // Write FF46 for one cycle, then check the START cycle (reading FF46 back).
    task automatic start_dma(input logic [7:0] v);
        tick;
        drive(1'b0, 1'b1, 16'hFF46, v);
        #1;
        chk("ff46_write_not_forwarded", ext_wr_en, 1'b0);
        tick;
        drive(1'b1, 1'b0, 16'hFF46, 8'h00);
        #1;
        chk("start_active", dma_active, 1'b1);
        chk("start_no_oam_we", oam_we, 1'b0);
        chk("start_no_ext_rd", ext_rd_en, 1'b0);
        chk("start_ff46_readback", cpu_rdata, v);
    endtask

    // n transfer cycles from source page hi. Optionally probe CPU blocking,
    // and rewrite FF46 in transfer restart_k.
    task automatic xfers(input logic [7:0] hi, input int n, input bit probe,
                         input int restart_k, input logic [7:0] new_v);
        for (int k = 0; k < n; k++) begin
            tick;
            if (k == restart_k)          drive(1'b0, 1'b1, 16'hFF46, new_v);
            else if (probe && k == 10)   drive(1'b1, 1'b0, 16'hC000, 8'h00);
            else if (probe && k == 11)   drive(1'b0, 1'b1, 16'hFF90, 8'h77);
            else if (probe && k == 12)   drive(1'b1, 1'b0, 16'hFF90, 8'h00);
            else if (probe && k == 13)   drive(1'b0, 1'b1, 16'hC000, 8'h12);
            else                         idle();
            #1;
            chk("xfer_active", dma_active, 1'b1);
            chk("xfer_oam_we", oam_we, 1'b1);
            chk("xfer_ext_rd", ext_rd_en, 1'b1);
            chk("xfer_ext_wr", ext_wr_en, 1'b0);
            chk("xfer_ext_addr", ext_addr, {hi, 8'(k)});
            chk("xfer_oam_addr", oam_addr, 16'(k));
            chk("xfer_oam_wdata", oam_wdata, 16'(8'(k) ^ 8'h5A));
            if (probe && k == 10) chk("blocked_read_ff", cpu_rdata, 8'hFF);
            if (probe && k == 12) chk("hram_during_dma", cpu_rdata, 8'h77);
        end
    endtask

    task automatic end_dma();
        tick;
        idle();
        #1;
        chk("end_inactive", dma_active, 1'b0);
        chk("end_no_oam_we", oam_we, 1'b0);
        chk("end_no_ext_rd", ext_rd_en, 1'b0);
    endtask
`endif

    // ---------------- main sequence ----------------
    initial begin
        for (int i = 0; i < 256; i++) oam_mem[i] = 8'h00;

        // Reset: hold for three edges with the CPU idle.
        idle();
        rst_n = 1'b0;
        repeat (3) tick;
        chk("rst_ext_rd", ext_rd_en, 1'b0);
        chk("rst_ext_wr", ext_wr_en, 1'b0);
        chk("rst_ext_addr", ext_addr, 16'h0000);
        chk("rst_ext_wdata", ext_wdata, 8'h00);
        chk("rst_oam_we", oam_we, 1'b0);
        chk("rst_oam_addr", oam_addr, 8'h00);
        chk("rst_oam_wdata", oam_wdata, 8'h00);
        chk("rst_dma_active", dma_active, 1'b0);
        chk("rst_ie", ie, 5'h00);
        chk("rst_rdata_idle", cpu_rdata, 8'hFF);
        rst_n = 1'b1;

        // Decode vectors, applied one per cycle.
        vecs.push_back(mk(0, 1, 16'hFF80, 8'hA5, 8'hFF, 0, 0, 16'h0000, 8'h00, 5'h00));
        vecs.push_back(mk(0, 1, 16'hFFFE, 8'h3C, 8'hFF, 0, 0, 16'h0000, 8'h00, 5'h00));
        vecs.push_back(mk(1, 0, 16'hFF80, 8'h00, 8'hA5, 0, 0, 16'h0000, 8'h00, 5'h00));
        vecs.push_back(mk(1, 0, 16'hFFFE, 8'h00, 8'h3C, 0, 0, 16'h0000, 8'h00, 5'h00));
        vecs.push_back(mk(0, 1, 16'hFFFF, 8'hFF, 8'hFF, 0, 0, 16'h0000, 8'h00, 5'h00));
        vecs.push_back(mk(1, 0, 16'hFFFF, 8'h00, 8'hFF, 0, 0, 16'h0000, 8'h00, 5'h1F));
        vecs.push_back(mk(0, 1, 16'hFFFF, 8'h00, 8'hFF, 0, 0, 16'h0000, 8'h00, 5'h1F));
        vecs.push_back(mk(1, 0, 16'hFFFF, 8'h00, 8'hE0, 0, 0, 16'h0000, 8'h00, 5'h00));
        vecs.push_back(mk(1, 0, 16'hC000, 8'h00, 8'h5A, 1, 0, 16'hC000, 8'h00, 5'h00));
        vecs.push_back(mk(0, 1, 16'hC123, 8'h99, 8'hFF, 0, 1, 16'hC123, 8'h99, 5'h00));
        vecs.push_back(mk(1, 1, 16'hFF81, 8'h11, 8'hFF, 0, 0, 16'h0000, 8'h00, 5'h00));
        vecs.push_back(mk(1, 0, 16'hFF81, 8'h00, 8'h11, 0, 0, 16'h0000, 8'h00, 5'h00));
        vecs.push_back(mk(0, 0, 16'hC000, 8'h33, 8'hFF, 0, 0, 16'h0000, 8'h00, 5'h00));
        vecs.push_back(mk(1, 0, 16'hFF7F, 8'h00, 8'h25, 1, 0, 16'hFF7F, 8'h00, 5'h00));
        vecs.push_back(mk(1, 1, 16'hC000, 8'h44, 8'hFF, 0, 1, 16'hC000, 8'h44, 5'h00));
`ifdef MEM_BUS_DMA_EN
        vecs.push_back(mk(1, 0, 16'hFF46, 8'h00, 8'h00, 0, 0, 16'h0000, 8'h00, 5'h00));
`else
        vecs.push_back(mk(1, 0, 16'hFF46, 8'h00, 8'h1C, 1, 0, 16'hFF46, 8'h00, 5'h00));
`endif
        foreach (vecs[i]) begin
            tick;
            drive(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            #1;
            chk($sformatf("vec%0d_rdata", i), cpu_rdata, vecs[i].exp_rdata);
            chk($sformatf("vec%0d_ext_rd", i), ext_rd_en, vecs[i].exp_xrd);
            chk($sformatf("vec%0d_ext_wr", i), ext_wr_en, vecs[i].exp_xwr);
            chk($sformatf("vec%0d_ext_addr", i), ext_addr, vecs[i].exp_xaddr);
            chk($sformatf("vec%0d_ext_wdata", i), ext_wdata, vecs[i].exp_xwdata);
            chk($sformatf("vec%0d_ie", i), ie, vecs[i].exp_ie);
        end

        // Randomized accesses against the reference model. Fill HRAM first
        // so that every model location is known.
        ie_m = 5'h00;
        dma_reg_m = 8'h00;
        for (int a = 0; a < 127; a++) begin
            logic [7:0] v;
            v = 8'($urandom);
            tick;
            drive(1'b0, 1'b1, 16'hFF80 + 16'(a), v);
            #1;
            chk("fill_no_ext_wr", ext_wr_en, 1'b0);
            hram_m[a] = v;
        end
        for (int n = 0; n < 300; n++) begin
            logic [15:0] a;
            logic        rd, wr, is_ie_m, is_hr_m, is_dr_m, is_ext_m;
            logic [7:0]  d, e_rdata;
            int          sel;
            sel = $urandom_range(0, 4);
            case (sel)
                0:       a = 16'hFF80 + 16'($urandom_range(0, 126));
                1:       a = 16'hFFFF;
                2:       a = 16'($urandom);
                3:       a = ($urandom_range(0, 1) == 0) ? 16'hFF7F : 16'hFF46;
                default: a = 16'hFF00 | 16'($urandom_range(0, 255));
            endcase
            rd = 1'($urandom_range(0, 1));
            wr = ($urandom_range(0, 2) == 0);
            d  = 8'($urandom);
            is_ie_m  = (a == 16'hFFFF);
            is_hr_m  = (a >= 16'hFF80) && (a <= 16'hFFFE);
`ifdef MEM_BUS_DMA_EN
            is_dr_m  = (a == 16'hFF46);
            if (is_dr_m) wr = 1'b0;   // a DMA start is covered by the hand sequences
`else
            is_dr_m  = 1'b0;
`endif
            is_ext_m = !(is_ie_m || is_hr_m || is_dr_m);
            if (wr) rd = 1'b0;        // write wins
            e_rdata = 8'hFF;
            if (rd) begin
                if (is_ie_m)      e_rdata = {3'b111, ie_m};
                else if (is_hr_m) e_rdata = hram_m[a - 16'hFF80];
                else if (is_dr_m) e_rdata = dma_reg_m;
                else              e_rdata = a[7:0] ^ 8'h5A;
            end
            tick;
            drive(rd, wr, a, d);
            if (wr && $urandom_range(0, 1) == 1) cpu_rd_en = 1'b1;
            #1;
            chk("rnd_rdata", cpu_rdata, e_rdata);
            chk("rnd_ext_rd", ext_rd_en, is_ext_m && rd);
            chk("rnd_ext_wr", ext_wr_en, is_ext_m && wr);
            chk("rnd_ext_addr", ext_addr, (is_ext_m && (rd || wr)) ? a : 16'h0000);
            chk("rnd_ext_wdata", ext_wdata, (is_ext_m && wr) ? d : 8'h00);
            chk("rnd_ie", ie, ie_m);
            chk("rnd_dma_idle", dma_active, 1'b0);
            if (wr && is_ie_m) ie_m = d[4:0];
            if (wr && is_hr_m) hram_m[a - 16'hFF80] = d;
        end

`ifdef MEM_BUS_DMA_EN
        // Basic DMA with CPU blocking probes.
        start_dma(8'hC1);
        xfers(8'hC1, 160, 1'b1, -1, 8'h00);
        end_dma();
        for (int k = 0; k < 160; k++) chk($sformatf("oam_byte%0d", k), oam_mem[k], 8'(k) ^ 8'h5A);
        tick;
        drive(1'b1, 1'b0, 16'hC000, 8'h00);
        #1;
        chk("post_dma_ext_rd", ext_rd_en, 1'b1);
        chk("post_dma_rdata", cpu_rdata, 8'h5A);

        // Echo source, restarted at transfer 50 with source 80.
        start_dma(8'hE3);
        xfers(8'hC3, 51, 1'b0, 50, 8'h80);
        tick;
        drive(1'b1, 1'b0, 16'hFF46, 8'h00);
        #1;
        chk("restart_start_active", dma_active, 1'b1);
        chk("restart_start_no_oam_we", oam_we, 1'b0);
        chk("restart_ff46", cpu_rdata, 8'h80);
        xfers(8'h80, 160, 1'b0, -1, 8'h00);
        end_dma();

        // Reset in transfer 20.
        start_dma(8'hC1);
        xfers(8'hC1, 20, 1'b0, -1, 8'h00);
        tick;
        idle();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_last_we", oam_we, 1'b1);
        chk("rst_mid_last_addr", ext_addr, 16'hC114);
        tick;
        rst_n = 1'b1;
        drive(1'b1, 1'b0, 16'hFF46, 8'h00);
        #1;
        chk("rst_mid_oam_we", oam_we, 1'b0);
        chk("rst_mid_active", dma_active, 1'b0);
        chk("rst_mid_ff46", cpu_rdata, 8'h00);
        chk("rst_mid_ie", ie, 5'h00);
        tick;
        drive(1'b1, 1'b0, 16'hFF90, 8'h00);
        #1;
        chk("rst_mid_hram_kept", cpu_rdata, 8'h77);
        chk("rst_mid_oam_kept", oam_mem[19], 8'h13 ^ 8'h5A);
`else
        // Without the engine, FF46 is an ordinary external address.
        tick;
        drive(1'b0, 1'b1, 16'hFF46, 8'h55);
        #1;
        chk("nodma_ff46_ext_wr", ext_wr_en, 1'b1);
        chk("nodma_ff46_ext_addr", ext_addr, 16'hFF46);
        chk("nodma_ff46_ext_wdata", ext_wdata, 8'h55);
        tick;
        drive(1'b1, 1'b0, 16'hFF46, 8'h00);
        #1;
        chk("nodma_active", dma_active, 1'b0);
        chk("nodma_oam_we", oam_we, 1'b0);
        chk("nodma_oam_addr", oam_addr, 8'h00);
        chk("nodma_oam_wdata", oam_wdata, 8'h00);
        chk("nodma_ff46_ext_rd", ext_rd_en, 1'b1);
        chk("nodma_ff46_rdata", cpu_rdata, 8'h1C);
`endif

        tick;
        idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_bus.md
# mem_bus

Memory bus controller directly downstream of the CPU core. It decodes every CPU bus access into three targets: internal high RAM (HRAM), the interrupt-enable register, or the external system bus (cartridge, WRAM, VRAM, other I/O). It also owns the OAM DMA engine. While DMA runs, the engine takes over the external bus and copies 160 bytes into OAM, and the CPU is limited to HRAM.

## Interface
Parameters:
- `HRAM_BASE`, default 16'hFF80: first HRAM address. HRAM spans `HRAM_BASE`..16'hFFFE (127 bytes).
- `DMA_LEN`, default 160: bytes copied per DMA.

Ports:
- `clk`, in, 1: system clock. One edge is one machine cycle.
- `rst_n`, in, 1: synchronous, active-low reset.
- `cpu_rd_en`, in, 1: CPU read strobe.
- `cpu_wr_en`, in, 1: CPU write strobe.
- `cpu_addr`, in, 16: CPU address.
- `cpu_wdata`, in, 8: CPU write data.
- `cpu_rdata`, out, 8: read data to the CPU, combinational in the same cycle.
- `ext_rd_en`, out, 1: external bus read strobe.
- `ext_wr_en`, out, 1: external bus write strobe.
- `ext_addr`, out, 16: external bus address.
- `ext_wdata`, out, 8: external bus write data.
- `ext_rdata`, in, 8: external bus read data, valid combinationally in the same cycle.
- `oam_we`, out, 1: OAM write strobe.
- `oam_addr`, out, 8: OAM byte index, 0..159.
- `oam_wdata`, out, 8: OAM write data.
- `dma_active`, out, 1: high from the DMA start cycle through the last transfer.
- `ie`, out, 5: interrupt-enable bits (FFFF[4:0]).

## Operation
- **Decode, CPU view:**
  - FFFF: IE register. Reads return {3'b111, ie}.
  - HRAM range: internal array.
  - FF46: DMA register. Reads return the last written value.
  - Everything else: forwarded to the external bus.
- **Forwarding rules:**
  - `ext_*` mirrors `cpu_*` for forwarded accesses only.
  - Internal accesses drive `ext_rd_en` = `ext_wr_en` = 0.
  - `cpu_rdata` = 8'hFF when no read is active.
- **HRAM:** 127x8 register array. Writes take effect at the clock edge. Reads are combinational. Contents are not reset.
- **DMA FSM states:** IDLE, START, XFER.
  - IDLE -> START: CPU writes FF46. `dma_reg` <= `cpu_wdata`.
  - START -> XFER: after 1 cycle. `idx` <= 0.
  - XFER:
    - Each cycle: `ext_rd_en` = 1, `ext_addr` = {`src_hi`, `idx`}, `oam_we` = 1, `oam_addr` = `idx`, `oam_wdata` = `ext_rdata`.
    - `idx` increments each cycle. After `idx` = `DMA_LEN`-1 the FSM returns to IDLE.
  - Source high byte: `src_hi` = `dma_reg` for values < 8'hE0. For values >= 8'hE0, `src_hi` = `dma_reg` & 8'hDF (echo of WRAM). Example: E3 -> C3.
- **CPU during START and XFER:**
  - HRAM, FF46 and FFFF accesses proceed normally.
  - All other reads return 8'hFF.
  - All other writes are dropped.
  - The CPU never drives `ext_*`.
- **Restart:** a CPU write to FF46 during START or XFER lets the current cycle's transfer complete. The next cycle is START with the new source and `idx` reset.
- **Simultaneous CPU reads and writes** are not generated by the CPU. If both strobes are high, the write wins and `cpu_rdata` = 8'hFF.

## Timing
- **Reset values:**
  - All `ext_*` outputs, `oam_we`, `oam_addr`, `oam_wdata`, `dma_active`, `ie` = 0.
  - `dma_reg` = 8'h00. FSM = IDLE.
- **CPU read latency:** 0 cycles; combinational path `cpu_addr` -> `cpu_rdata`.
- **CPU write latency:** visible on the next read after the clock edge.
- **DMA cycle count:** a write at edge N gives START in cycle N+1, transfers in cycles N+2..N+161, and IDLE at N+162.
- **`dma_active`** is high in cycles N+1..N+161, total `DMA_LEN`+1 cycles.
- **Reset mid-DMA:**
  - No `oam_we` in the cycle after `rst_n` is sampled low.
  - FSM returns to IDLE.
  - OAM keeps the bytes already written.

## Configuration
- Macro: `MEM_BUS_DMA_EN`.
- **Defined:** DMA engine, FF46 register and CPU bus blocking are present, as described above.
- **Undefined:**
  - No FSM.
  - FF46 is forwarded to the external bus like any other address.
  - `dma_active`, `oam_we`, `oam_addr`, `oam_wdata` are tied to 0.

## Test plan
- **HRAM:** write 8'hA5 to FF80 and 8'h3C to FFFE. Read back -> `cpu_rdata` = A5 and 3C, with `ext_rd_en` and `ext_wr_en` = 0 throughout.
- **IE register:** write 8'hFF to FFFF -> `ie` = 5'h1F, and a read returns FF. Write 8'h00 -> a read returns 8'hE0.
- **Basic DMA:**
  - Stimulus: write 8'hC1 to FF46; external memory model returns low address ^ 8'h5A.
  - Required: `dma_active` lasts 161 cycles, `ext_addr` runs C100..C19F, and OAM byte k = k ^ 5A for k = 0..159.
- **CPU blocking during DMA:**
  - A read of C000 returns FF with no `ext` strobe from the CPU.
  - A write of 8'h77 to FF90 then reads back 77.
- **Echo source and restart:**
  - Write 8'hE3 to FF46 -> source C3xx.
  - Rewrite FF46 = 8'h80 at transfer 50 -> one START cycle follows, then 160 transfers from 8000.
- **Reset mid-DMA:** assert `rst_n` = 0 at transfer 20 -> `oam_we` = 0 from the next cycle, `dma_active` = 0, FF46 reads 00.
